// File: rtl/psum_out_sched.sv
// Output scheduler for systolic partial sums: drains NUM_CH column channels
// round-robin into one truncated activation stream behind a single output register.
`ifndef DATA_INTER_WIDTH
`define DATA_INTER_WIDTH 32
`endif
`ifndef DATA_ACT_WIDTH
`define DATA_ACT_WIDTH 8
`endif
`ifndef TRUNC_UP_BIT
`define TRUNC_UP_BIT 14
`endif
`ifndef TRUNC_DOWN_BIT
`define TRUNC_DOWN_BIT 8
`endif
`ifndef POSITIVE_UP_BOUND
`define POSITIVE_UP_BOUND 7'h7F
`endif
`ifndef NEGATIVE_DOWN_BOUND
`define NEGATIVE_DOWN_BOUND 7'h00
`endif

module psum_out_sched #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic [LEN_W-1:0]                               cfg_len,
  input  logic [NUM_CH-1:0]                              ch_valid,
  input  logic [NUM_CH*`DATA_INTER_WIDTH-1:0]            ch_data,
  output logic [NUM_CH-1:0]                              ch_ready,
  output logic                                           dout_valid,
  output logic [`DATA_ACT_WIDTH-1:0]                     dout,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] dout_ch,
  input  logic                                           dout_ready,
  output logic                                           busy,
  output logic                                           done,
  output logic [15:0]                                    sat_cnt
);

  localparam int unsigned W     = `DATA_INTER_WIDTH;
  localparam int unsigned ACT_W = `DATA_ACT_WIDTH;
  localparam int unsigned UP    = `TRUNC_UP_BIT;
  localparam int unsigned DN    = `TRUNC_DOWN_BIT;
  localparam int unsigned MAG_W = ACT_W - 1;
  localparam int unsigned HI_W  = W - 1 - UP;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q [NUM_CH];
  logic [LEN_W-1:0]   cnt_d [NUM_CH];
  logic [CH_W-1:0]    last_q;
  logic               out_valid_q;
  logic [ACT_W-1:0]   dout_q;
  logic [CH_W-1:0]    dout_ch_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        sat_q;

  logic               start_acc;
  logic               can_load;
  logic               gnt_vld;
  logic [CH_W-1:0]    gnt_idx;
  logic [NUM_CH-1:0]  elig;
  logic               all_done;
  logic [W-1:0]       gnt_data;
  logic [HI_W-1:0]    hi_bits;
  logic               sat_hit;
  logic [MAG_W-1:0]   mag;
  logic               unused_lsb;

  assign start_acc  = (state_q == S_IDLE) && start;
  assign can_load   = !out_valid_q || dout_ready;
  assign unused_lsb = ^gnt_data[DN-1:0];

  // Round-robin grant starting one past the last granted channel.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    ch_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_valid[i] && (cnt_q[i] < len_q);
    end
    if ((state_q == S_RUN) && can_load) begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        if (!gnt_vld && elig[(32'(last_q) + k) % NUM_CH]) begin
          gnt_vld = 1'b1;
          gnt_idx = CH_W'((32'(last_q) + k) % NUM_CH);
        end
      end
    end
    if (gnt_vld) begin
      ch_ready[gnt_idx] = 1'b1;
    end
  end

  // Counter advance and tile-complete detection including this cycle's transfer.
  always_comb begin
    all_done = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_vld && (gnt_idx == CH_W'(i))) begin
        cnt_d[i] = cnt_q[i] + LEN_W'(1);
      end
      if (cnt_d[i] != len_q) begin
        all_done = 1'b0;
      end
    end
  end

  // Saturating truncation of the granted partial sum.
  always_comb begin
    gnt_data = ch_data[gnt_idx*W +: W];
    hi_bits  = gnt_data[W-1:UP+1];
    if (!gnt_data[W-1]) begin
      sat_hit = |hi_bits;
      mag     = sat_hit ? MAG_W'(`POSITIVE_UP_BOUND) : MAG_W'(gnt_data[UP:DN]);
    end else begin
      sat_hit = ~&hi_bits;
      mag     = sat_hit ? MAG_W'(`NEGATIVE_DOWN_BOUND) : MAG_W'(gnt_data[UP:DN]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (cfg_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (all_done) state_d = S_DRAIN;
      S_DRAIN: if (can_load) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_ch_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      if (start_acc) begin
        len_q  <= cfg_len;
        last_q <= CH_W'(NUM_CH - 1);
        sat_q  <= '0;
        for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else if (gnt_vld) begin
        last_q <= gnt_idx;
        for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        if (sat_hit && (sat_q != 16'hFFFF)) sat_q <= sat_q + 16'd1;
      end
      if (gnt_vld) begin
        out_valid_q <= 1'b1;
        dout_q      <= {gnt_data[W-1], mag};
        dout_ch_q   <= gnt_idx;
      end else if (dout_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign dout_valid = out_valid_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat_cnt    = sat_q;

endmodule

// File: tb/tb_psum_out_sched.sv
// Directed scoreboard bench for psum_out_sched: truncation, fairness,
// backpressure, empty tile, ignored start and mid-tile reset.
module tb_psum_out_sched;

  localparam int NUM_CH = 4;
  localparam int LEN_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [LEN_W-1:0]       cfg_len = '0;
  logic [NUM_CH-1:0]      ch_valid = '0;
  logic [NUM_CH*32-1:0]   ch_data = '0;
  logic [NUM_CH-1:0]      ch_ready;
  logic                   dout_valid;
  logic [7:0]             dout;
  logic [1:0]             dout_ch;
  logic                   dout_ready = 1'b1;
  logic                   busy;
  logic                   done;
  logic [15:0]            sat_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] chq [NUM_CH][$];
  logic [NUM_CH-1:0] fire = '0;
  logic [7:0] exp_d[$];
  logic [1:0] exp_ch[$];
  logic [7:0] log_d[$];
  logic [1:0] log_ch[$];
  int  done_cnt = 0;
  bit  ready_seen = 1'b0;
  int  sat_exp = 0;

  psum_out_sched #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .dout_valid(dout_valid), .dout(dout), .dout_ch(dout_ch),
    .dout_ready(dout_ready), .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference truncation: arithmetic shift then clamp to the signed 8-bit range.
  function automatic logic [7:0] tmodel(input logic [31:0] d);
    int x;
    x = $signed(d) >>> 8;
    if (x > 127)  return 8'h7F;
    if (x < -128) return 8'h80;
    return x[7:0];
  endfunction

  function automatic bit tsat(input logic [31:0] d);
    int x;
    x = $signed(d) >>> 8;
    return (x > 127) || (x < -128);
  endfunction

  // Scoreboard: push on channel handshake, pop on output handshake.
  always @(negedge clk) begin
    logic [31:0] d;
    if (rst_n) begin
      if (dout_valid && dout_ready) begin
        if (exp_d.size() == 0) begin
          chk("sb_underflow", 32'(exp_d.size()), 32'd1);
        end else begin
          chk("dout", 32'(dout), 32'(exp_d.pop_front()));
          chk("dout_ch", 32'(dout_ch), 32'(exp_ch.pop_front()));
        end
        log_d.push_back(dout);
        log_ch.push_back(dout_ch);
      end
      chk("ch_ready_onehot0", 32'($onehot0(ch_ready)), 32'd1);
      if (|ch_ready) ready_seen = 1'b1;
      if (done) done_cnt++;
      fire = ch_valid & ch_ready;
      for (int i = 0; i < NUM_CH; i++) begin
        if (fire[i]) begin
          d = ch_data[i*32 +: 32];
          exp_d.push_back(tmodel(d));
          exp_ch.push_back(2'(i));
          if (tsat(d)) sat_exp++;
        end
      end
    end else begin
      fire = '0;
    end
  end

  // Channel sources: retire accepted heads, then present the next head.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fire[i] && chq[i].size() > 0) void'(chq[i].pop_front());
    end
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_valid[i] = (chq[i].size() > 0);
      ch_data[i*32 +: 32] = (chq[i].size() > 0) ? chq[i][0] : 32'h0;
    end
  end

  task automatic start_tile(input int len);
    sat_exp = 0;
    cfg_len = LEN_W'(len);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    cfg_len = LEN_W'(len);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_sat_cnt"}, 32'(sat_cnt), 32'(sat_exp));
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_sb_empty"}, 32'(exp_d.size()), 32'd0);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int budget);
    int n;
    n = 0;
    while (log_d.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_beats_reached"}, 32'(log_d.size() >= cnt), 32'd1);
  endtask

  task automatic clear_logs();
    log_d.delete();
    log_ch.delete();
  endtask

  task automatic load_all(input int per_ch);
    for (int b = 0; b < per_ch; b++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        logic [31:0] d;
        d = $urandom;
        if (((b + i) % 2) == 1) d = $signed(d) >>> 13;
        chq[i].push_back(d);
      end
    end
  endtask

  task automatic check_rr(input string tag, input int beats);
    chk({tag, "_beats"}, 32'(log_ch.size()), 32'(beats));
    for (int i = 0; i < beats && i < log_ch.size(); i++) begin
      chk({tag, "_order"}, 32'(log_ch[i]), 32'(i % NUM_CH));
    end
  endtask

  initial begin
    int d0;
    logic [7:0] tr_exp [4];
    logic [7:0] hold_d;
    logic [1:0] hold_ch;
    int per_ch [NUM_CH];
    tr_exp = '{8'h10, 8'h7F, 8'hFF, 8'h80};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_ch", 32'(dout_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Truncation
    clear_logs();
    d0 = done_cnt;
    chq[0].push_back(32'h0000_1000);
    chq[1].push_back(32'h0001_0000);
    chq[2].push_back(32'hFFFF_FF00);
    chq[3].push_back(32'hFFFF_7F00);
    start_tile(1);
    wait_done("trunc", 60);
    chk("trunc_beats", 32'(log_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_d.size(); i++) chk("trunc_dout", 32'(log_d[i]), 32'(tr_exp[i]));
    chk("trunc_sat_const", 32'(sat_cnt), 32'd2);
    repeat (3) @(posedge clk); #1;
    chk("trunc_sat_hold", 32'(sat_cnt), 32'd2);
    chk("trunc_done_once", 32'(done_cnt - d0), 32'd1);
    chk("trunc_idle_busy", 32'(busy), 32'd0);

    // Fairness
    clear_logs();
    d0 = done_cnt;
    load_all(3);
    start_tile(3);
    wait_done("fair", 100);
    check_rr("fair", 12);
    chk("fair_done_once", 32'(done_cnt - d0), 32'd1);

    // Backpressure
    clear_logs();
    d0 = done_cnt;
    load_all(4);
    start_tile(4);
    wait_log("bp", 3, 100);
    @(posedge clk); #1;
    dout_ready = 1'b0;
    hold_d  = dout;
    hold_ch = dout_ch;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(dout_valid), 32'd1);
      chk("bp_dout_stable", 32'(dout), 32'(hold_d));
      chk("bp_ch_stable", 32'(dout_ch), 32'(hold_ch));
      chk("bp_ch_ready", 32'(ch_ready), 32'd0);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    wait_done("bp", 120);
    chk("bp_beats", 32'(log_ch.size()), 32'd16);
    for (int i = 0; i < NUM_CH; i++) per_ch[i] = 0;
    foreach (log_ch[k]) per_ch[log_ch[k]]++;
    for (int i = 0; i < NUM_CH; i++) chk("bp_per_ch", 32'(per_ch[i]), 32'd4);
    chk("bp_done_once", 32'(done_cnt - d0), 32'd1);

    // Empty tile
    clear_logs();
    d0 = done_cnt;
    ready_seen = 1'b0;
    start_tile(0);
    @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("empty_done_pulse", 32'(done), 32'd0);
    chk("empty_no_ready", 32'(ready_seen), 32'd0);
    chk("empty_done_once", 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;

    // Start during RUN is ignored
    clear_logs();
    d0 = done_cnt;
    load_all(4);
    start_tile(2);
    @(posedge clk); #1;
    pulse_start(7);
    wait_done("ign", 100);
    check_rr("ign", 8);
    for (int i = 0; i < NUM_CH; i++) chk("ign_left", 32'(chq[i].size()), 32'd2);
    chk("ign_done_once", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < NUM_CH; i++) chq[i].delete();
    repeat (2) @(posedge clk); #1;

    // Reset mid-tile, then a fresh tile
    clear_logs();
    d0 = done_cnt;
    load_all(4);
    start_tile(4);
    wait_log("rst", 5, 100);
    #1 rst_n = 1'b0;
    for (int i = 0; i < NUM_CH; i++) chq[i].delete();
    exp_d.delete();
    exp_ch.delete();
    @(negedge clk);
    chk("rst_mid_valid", 32'(dout_valid), 32'd0);
    chk("rst_mid_dout", 32'(dout), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(ch_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    clear_logs();
    load_all(2);
    start_tile(2);
    wait_done("rst_new", 100);
    check_rr("rst_new", 8);
    chk("rst_new_done_once", 32'(done_cnt - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
